// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped refill cache.
// Field extractors work on a zero-extended 32-bit address; callers cast to the field width.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } cacheState_t;

    function automatic int calcTagW(input int addrW, input int indexW, input int offsetW);
        return addrW - indexW - offsetW;
    endfunction

    function automatic int calcLineWords(input int offsetW);
        return 1 << offsetW;
    endfunction

    function automatic logic [31:0] addrTag(input logic [31:0] addr, input int indexW, input int offsetW);
        return addr >> (indexW + offsetW);
    endfunction

    function automatic logic [31:0] addrIndex(input logic [31:0] addr, input int indexW, input int offsetW);
        return (addr >> offsetW) & ((32'd1 << indexW) - 32'd1);
    endfunction

    function automatic logic [31:0] addrOffset(input logic [31:0] addr, input int offsetW);
        return addr & ((32'd1 << offsetW) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage: data and tag RAMs with registered reads plus a resettable valid vector.
// Reads are only issued when a request is accepted, so they never collide with refill writes.
module cache_line_store #(
    parameter int WORD     = 32,
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clearAll,
    input  logic                wrEn,
    input  logic [INDEX_W-1:0]  wrIndex,
    input  logic [OFFSET_W-1:0] wrOffset,
    input  logic [WORD-1:0]     wrData,
    input  logic                wrSetTag,
    input  logic [TAG_W-1:0]    wrTag,
    input  logic                rdEn,
    input  logic [INDEX_W-1:0]  rdIndex,
    input  logic [OFFSET_W-1:0] rdOffset,
    output logic [WORD-1:0]     rdData,
    output logic [TAG_W-1:0]    rdTag,
    output logic                rdValid
);

    localparam int LINES = 2 ** INDEX_W;
    localparam int DEPTH = LINES << OFFSET_W;

    logic [WORD-1:0]  dataMem [DEPTH];
    logic [TAG_W-1:0] tagMem  [LINES];
    logic [LINES-1:0] validBits;
    logic [LINES-1:0] validNext;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            dataMem[{wrIndex, wrOffset}] <= wrData;
        end
        if (rdEn) begin
            rdData <= dataMem[{rdIndex, rdOffset}];
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn && wrSetTag) begin
            tagMem[wrIndex] <= wrTag;
        end
        if (rdEn) begin
            rdTag <= tagMem[rdIndex];
        end
    end

    // Flush wins over a concurrent tag set; in practice the FSM never issues both.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : gValid
            assign validNext[gi] = clearAll ? 1'b0 :
                                   (wrEn && wrSetTag && wrIndex == INDEX_W'(gi)) ? 1'b1 :
                                   validBits[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validBits <= '0;
            rdValid   <= 1'b0;
        end else begin
            validBits <= validNext;
            if (rdEn) begin
                rdValid <= validBits[rdIndex];
            end
        end
    end

endmodule

// File: rtl/cache_dm_refill.sv
// Direct-mapped read-only cache with whole-line burst refill and saturating hit/miss counters.
// One request in flight; hits answer two cycles after acceptance, misses the cycle after the last beat.
module cache_dm_refill
    import cache_pkg::*;
#(
    parameter int WORD     = 32,
    parameter int ADDR_W   = 15,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [WORD-1:0]   resp_data,
    output logic              resp_hit,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [WORD-1:0]   mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W      = calcTagW(ADDR_W, INDEX_W, OFFSET_W);
    localparam int LINE_WORDS = calcLineWords(OFFSET_W);

    cacheState_t state, stateNext;

    logic [ADDR_W-1:0]   addrReg;
    logic [OFFSET_W-1:0] beatReg;
    logic [WORD-1:0]     respDataReg;
    logic                respHitReg;
    logic [CNT_W-1:0]    hitCountReg;
    logic [CNT_W-1:0]    missCountReg;

    logic [TAG_W-1:0]    reqTag;
    logic [INDEX_W-1:0]  reqIndex;
    logic [OFFSET_W-1:0] reqOffset;
    logic [INDEX_W-1:0]  inIndex;
    logic [OFFSET_W-1:0] inOffset;

    logic [WORD-1:0]     rdData;
    logic [TAG_W-1:0]    rdTag;
    logic                rdValid;
    logic                hit;
    logic                accept;
    logic                lastBeat;
    logic                flushAll;
    logic                refillWr;

    assign reqTag    = TAG_W'(addrTag(32'(addrReg), INDEX_W, OFFSET_W));
    assign reqIndex  = INDEX_W'(addrIndex(32'(addrReg), INDEX_W, OFFSET_W));
    assign reqOffset = OFFSET_W'(addrOffset(32'(addrReg), OFFSET_W));
    assign inIndex   = INDEX_W'(addrIndex(32'(req_addr), INDEX_W, OFFSET_W));
    assign inOffset  = OFFSET_W'(addrOffset(32'(req_addr), OFFSET_W));

    assign accept   = req_valid && req_ready;
    assign hit      = rdValid && (rdTag == reqTag);
    assign refillWr = (state == REFILL) && mem_rvalid;
    assign lastBeat = refillWr && (beatReg == OFFSET_W'(LINE_WORDS - 1));

    cache_line_store #(
        .WORD    (WORD),
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .OFFSET_W(OFFSET_W)
    ) lineStore (
        .clk     (clk),
        .rst     (rst),
        .clearAll(flushAll),
        .wrEn    (refillWr),
        .wrIndex (reqIndex),
        .wrOffset(beatReg),
        .wrData  (mem_rdata),
        .wrSetTag(lastBeat),
        .wrTag   (reqTag),
        .rdEn    (accept),
        .rdIndex (inIndex),
        .rdOffset(inOffset),
        .rdData  (rdData),
        .rdTag   (rdTag),
        .rdValid (rdValid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        flushAll   = 1'b0;
        case (state)
            IDLE: begin
                flushAll  = flush;
                req_ready = !flush;
                if (!flush && req_valid) begin
                    stateNext = LOOKUP;
                end
            end
            LOOKUP:   stateNext = hit ? RESP : MISS_REQ;
            MISS_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    stateNext = REFILL;
                end
            end
            REFILL: begin
                if (lastBeat) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // mem_addr is gated by mem_req so it reads zero whenever no fetch is pending.
    assign mem_addr   = mem_req ? {reqTag, reqIndex, {OFFSET_W{1'b0}}} : '0;
    assign resp_data  = respDataReg;
    assign resp_hit   = respHitReg;
    assign hit_count  = hitCountReg;
    assign miss_count = missCountReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrReg      <= '0;
            beatReg      <= '0;
            respDataReg  <= '0;
            respHitReg   <= 1'b0;
            hitCountReg  <= '0;
            missCountReg <= '0;
        end else begin
            if (accept) begin
                addrReg <= req_addr;
            end
            case (state)
                LOOKUP: begin
                    if (hit) begin
                        respDataReg <= rdData;
                        respHitReg  <= 1'b1;
                        if (hitCountReg != '1) begin
                            hitCountReg <= hitCountReg + CNT_W'(1);
                        end
                    end else begin
                        respHitReg <= 1'b0;
                        if (missCountReg != '1) begin
                            missCountReg <= missCountReg + CNT_W'(1);
                        end
                    end
                end
                MISS_REQ: begin
                    if (mem_ack) begin
                        beatReg <= '0;
                    end
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        beatReg <= beatReg + OFFSET_W'(1);
                        // Requested word is captured on the fly so no extra read cycle is needed.
                        if (beatReg == reqOffset) begin
                            respDataReg <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
